mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
- REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width (>=8, even).
- REQ-002 The block SHALL have one parameter: OPW, default 3, width of the op code.
- REQ-003 Port: clk, input, 1, single clock; all state updates on the rising edge.
- REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
- REQ-005 Port: start, input, 1, request to launch the operation in op.
- REQ-006 Port: op, input, OPW, 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved.
- REQ-007 Port: a, input, WIDTH, multiplicand, dividend, or move source.
- REQ-008 Port: b, input, WIDTH, multiplier or divisor.
- REQ-009 Port: cancel, input, 1, pipeline flush; aborts an in-flight operation.
- REQ-010 Port: busy, output, 1, high while an iterative operation is in flight.
- REQ-011 Port: done, output, 1, one-cycle pulse when hi/lo receive a multiply/divide result.
- REQ-012 Port: div_zero, output, 1, pulses with done when a divide had b==0.
- REQ-013 Port: hi, output, WIDTH, HI register.
- REQ-014 Port: lo, output, WIDTH, LO register.

Function
- REQ-015 FSM SHALL have states IDLE, CALC, FIN; reset state IDLE.
- REQ-016 start SHALL be accepted only in IDLE; start in CALC/FIN is ignored with no effect.
- REQ-017 MTHI/MTLO accepted: hi<=a (or lo<=a) on that edge, state stays IDLE, busy stays 0, no done.
- REQ-018 Reserved op accepted: no state change, no register write, no done.
- REQ-019 MULT/MULTU/DIV/DIVU accepted: latch operands and op, clear the iteration counter, go to CALC, busy=1 from the next cycle.
- REQ-020 CALC SHALL perform one radix-2 step per cycle for exactly WIDTH cycles: shift-add for multiply, restoring subtract for divide, operating on magnitudes.
- REQ-021 After the last step, the FSM SHALL go to FIN; in FIN it writes hi/lo, asserts done for that one cycle, and returns to IDLE.
- REQ-022 Latency SHALL be fixed: start accepted at edge N means done=1 in cycle N+WIDTH+1 and busy=0 from edge N+WIDTH+2; the result is visible on hi/lo in that same done cycle.
- REQ-023 Multiply results SHALL be the 2*WIDTH-bit product: {hi,lo}; MULT is signed, MULTU is unsigned.
- REQ-024 Divide results SHALL be lo=quotient, hi=remainder.
- REQ-025 DIV SHALL truncate toward zero: the quotient sign is a^b and the remainder takes the sign of a.
- REQ-026 DIV overflow (a=most-negative, b=-1) SHALL give lo=most-negative, hi=0, with no flag.
- REQ-027 Divide with b==0 SHALL still take full latency and give lo=all-ones, hi=a, div_zero=1 in the done cycle.
- REQ-028 cancel in CALC or FIN SHALL return the FSM to IDLE on the next edge, leave hi/lo unchanged, and produce no done.
- REQ-029 cancel in IDLE SHALL take priority over start: the start is dropped, including MTHI/MTLO.
- REQ-030 hi/lo SHALL hold their value whenever not written; reads are combinational from the registers.

Reset
- REQ-031 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and clear the counter.
- REQ-032 Reset asserted mid-CALC SHALL abandon the operation; after release, no done appears for it.
- REQ-033 The first start SHALL be accepted on the first rising edge with rst_n high.

Verification
- REQ-034 WIDTH=32, MULT a=0xFFFFFFFE(-2) b=3 -> done at cycle 33 after start; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- REQ-035 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- REQ-036 DIV a=-7 (0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- REQ-037 DIVU a=100 b=0 -> div_zero=1 with done, lo=0xFFFFFFFF, hi=100.
- REQ-038 MULTU launched, cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values; a second start while busy -> ignored, only one done observed.
- REQ-039 MTHI a=0x1234 then MTLO a=0x5678 on back-to-back cycles -> hi=0x1234, lo=0x5678, busy never 1; rst_n pulsed mid-DIV -> hi=lo=0, no done.

Source files
------------

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Purpose  : Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_last = c_CW'(WIDTH - 1);

    localparam logic [OPW-1:0] c_op_mult  = OPW'(0);
    localparam logic [OPW-1:0] c_op_multu = OPW'(1);
    localparam logic [OPW-1:0] c_op_div   = OPW'(2);
    localparam logic [OPW-1:0] c_op_divu  = OPW'(3);
    localparam logic [OPW-1:0] c_op_mthi  = OPW'(4);
    localparam logic [OPW-1:0] c_op_mtlo  = OPW'(5);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH:0]     r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0]   r_q;        // multiplier / quotient shift register
    logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bzero;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_md;
    logic               w_is_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_mul_t;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_is_md     = (op == c_op_mult) || (op == c_op_multu) ||
                      (op == c_op_div)  || (op == c_op_divu);
        w_is_signed = (op == c_op_mult) || (op == c_op_div);
        w_is_div    = (op == c_op_div)  || (op == c_op_divu);
        w_a_mag     = (w_is_signed && a[WIDTH-1]) ? -a : a;
        w_b_mag     = (w_is_signed && b[WIDTH-1]) ? -b : b;

        w_mul_sum   = {1'b0, r_acc[WIDTH-1:0]} + {1'b0, r_opb};
        w_mul_t     = r_q[0] ? w_mul_sum : {1'b0, r_acc[WIDTH-1:0]};
        w_div_sh    = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
        w_div_diff  = w_div_sh - {1'b0, r_opb};

        w_prod      = {r_acc[WIDTH-1:0], r_q};
        w_prod_fix  = r_neg_q ? -w_prod : w_prod;
        // Divide-by-zero forces an all-ones quotient; the remainder is already |a|.
        w_quo       = r_bzero ? {WIDTH{1'b1}} : (r_neg_q ? -r_q : r_q);
        w_rem       = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (start && !cancel) begin
                        if (w_is_md) begin
                            r_state  <= CALC;
                            r_busy   <= 1'b1;
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_q      <= w_a_mag;
                            r_opb    <= w_b_mag;
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r  <= w_is_signed && w_is_div && a[WIDTH-1];
                            r_bzero  <= w_is_div && (b == '0);
                        end else if (op == c_op_mthi) begin
                            r_hi <= a;
                        end else if (op == c_op_mtlo) begin
                            r_lo <= a;
                        end
                    end
                end
                CALC: begin
                    if (cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_is_div) begin
                            if (!w_div_diff[WIDTH]) begin
                                r_acc <= w_div_diff;
                                r_q   <= {r_q[WIDTH-2:0], 1'b1};
                            end else begin
                                r_acc <= w_div_sh;
                                r_q   <= {r_q[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            r_acc <= {1'b0, w_mul_t[WIDTH:1]};
                            r_q   <= {w_mul_t[0], r_q[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last)
                            r_state <= FIN;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    if (cancel) begin
                        r_busy <= 1'b0;
                    end else begin
                        // busy stays high through the done cycle and drops on the next edge
                        r_done <= 1'b1;
                        r_dz   <= r_bzero;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_iter
// Purpose  : Scoreboard bench for mdu_iter (WIDTH=32) with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int c_W = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic          cancel;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    mdu_iter #(.WIDTH(c_W), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [c_W-1:0] hi;
        logic [c_W-1:0] lo;
        logic           dz;
        int             acc;
    } exp_t;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc = 0;
    int             n_done = 0;
    logic [c_W-1:0] exp_hi = '0;
    logic [c_W-1:0] exp_lo = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [c_W-1:0] x, input logic [c_W-1:0] y,
                         output logic [c_W-1:0] mh, output logic [c_W-1:0] ml, output logic dz);
        logic signed [63:0]    sp;
        logic [63:0]           up;
        logic signed [c_W-1:0] sx;
        logic signed [c_W-1:0] sy;
        sx = x;
        sy = y;
        dz = 1'b0;
        mh = '0;
        ml = '0;
        case (o)
            3'd0: begin
                sp = 64'(sx) * 64'(sy);
                mh = sp[63:32];
                ml = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, x} * {32'd0, y};
                mh = up[63:32];
                ml = up[31:0];
            end
            default: begin
                if (y == '0) begin
                    dz = 1'b1;
                    mh = x;
                    ml = '1;
                end else if (o == 3'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    mh = '0;
                    ml = x;
                end else if (o == 3'd2) begin
                    ml = sx / sy;
                    mh = sx % sy;
                end else begin
                    ml = x / y;
                    mh = x % y;
                end
            end
        endcase
    endtask

    // Drive one start pulse from a negedge; accepted on the following posedge.
    task automatic launch(input logic [2:0] o, input logic [c_W-1:0] x, input logic [c_W-1:0] y,
                          input bit track);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (track) begin
            model(o, x, y, e.hi, e.lo, e.dz);
            e.acc = cyc + 1;
            sb.push_back(e);
            exp_hi = e.hi;
            exp_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
        check("hi_hold", {32'd0, hi}, {32'd0, exp_hi});
        check("lo_hold", {32'd0, lo}, {32'd0, exp_lo});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    check("spurious_done", {63'd0, done}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_hi", {32'd0, hi}, {32'd0, e.hi});
                    check("res_lo", {32'd0, lo}, {32'd0, e.lo});
                    check("res_dz", {63'd0, div_zero}, {63'd0, e.dz});
                    check("latency", 64'(cyc - e.acc), 64'd33);
                    check("busy_in_done", {63'd0, busy}, 64'd1);
                end
            end else begin
                check("dz_without_done", {63'd0, div_zero}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz", {63'd0, div_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed results, first start right after reset release
        launch(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);          wait_idle();
        launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);  wait_idle();
        launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);          wait_idle();
        launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_idle();
        launch(3'd3, 32'd100, 32'd0, 1'b1);                wait_idle();
        launch(3'd2, 32'hFFFF_FF00, 32'd0, 1'b1);          wait_idle();
        launch(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);  wait_idle();
        launch(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);          wait_idle();

        for (int i = 0; i < 12; i++) begin
            logic [c_W-1:0] ra;
            logic [c_W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 3) rb = '0;
            if (i % 5 == 4) rb = 32'hFFFF_FFFF;
            if (i % 4 == 1) rb = rb >> $urandom_range(8, 28);
            launch(3'($urandom_range(0, 3)), ra, rb, 1'b1);
            wait_idle();
        end

        // Cancel at cycle 10 of a MULTU
        launch(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        wait_idle();

        // Second start while busy is ignored
        d0 = n_done;
        launch(3'd3, 32'd1000, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        launch(3'd0, 32'd5, 32'd5, 1'b0);
        wait_idle();
        repeat (40) @(negedge clk);
        check("one_done", 64'(n_done - d0), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        // MTHI / MTLO back to back
        launch(3'd4, 32'h1234, 32'd0, 1'b0);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        launch(3'd5, 32'h5678, 32'd0, 1'b0);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        check("mthi_hi", {32'd0, hi}, 64'h1234);
        check("mtlo_lo", {32'd0, lo}, 64'h5678);
        exp_hi = 32'h1234;
        exp_lo = 32'h5678;

        // Reserved op and cancel-beats-start in IDLE
        launch(3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);
        check("rsvd_busy", {63'd0, busy}, 64'd0);
        cancel = 1'b1;
        launch(3'd4, 32'hDEAD_0000, 32'd0, 1'b0);
        launch(3'd2, 32'd9, 32'd3, 1'b0);
        cancel = 1'b0;
        check("idle_cancel_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        wait_idle();

        // Reset mid-DIV
        launch(3'd2, 32'd12345, 32'd17, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        wait_idle();

        // Normal operation resumes after reset
        launch(3'd3, 32'd100, 32'd7, 1'b1);
        wait_idle();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
